display_owner_arbiter: RTL and testbench
========================================

# display_owner_arbiter

Sequencer that owns the 4-digit seven-segment display and shares it between three producers: live score, combo pop-up and pre-round countdown. It also drives game-over blinking. It sits between the game logic and the multi-digit display driver, and its registered `value` and `enable_blink` outputs connect directly to the driver's inputs. It arbitrates event pulses by fixed priority and times each temporary view with internal counters.

## Interface
Parameters:
- `HOLD_CYCLES`, default 100_000_000: cycles a combo pop-up stays on screen (2 s at 50 MHz); must be ≥ 1.
- `TICK_CYCLES`, default 50_000_000: cycles per countdown step (1 s at 50 MHz); must be ≥ 1.
- `CD_SECONDS`, default 3: countdown start value, range 1–9999.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `score` in 14: live score, binary, may exceed 9999.
- `combo` in 14: current combo count, sampled on `combo_evt`.
- `combo_evt` in 1: one-cycle pulse requesting a combo pop-up.
- `start_cd` in 1: one-cycle pulse starting a countdown (new round).
- `game_over` in 1: one-cycle pulse freezing the final score.
- `value` out 14: number to display, always ≤ 9999.
- `enable_blink` out 1: blink request to the display driver.
- `owner` out 2: current view; 0 = SCORE, 1 = COMBO, 2 = COUNTDOWN, 3 = GAMEOVER.
- `cd_done` out 1: one-cycle pulse when the countdown finishes.

## Operation
- States: SCORE, COMBO, COUNTDOWN, GAMEOVER.
- Saturation: `sat(x)` = min(x, 9999), applied to every value loaded into `value`.
- Event priority within one cycle: `game_over` > `start_cd` > `combo_evt`. Lower-priority events in the same cycle are dropped, not queued.
- SCORE:
  - Every cycle, `value` ← `sat(score)`, `enable_blink` = 0.
  - `combo_evt` → COMBO: latch `sat(combo)`, hold counter ← `HOLD_CYCLES` − 1.
- COMBO:
  - `value` holds the latched combo.
  - Another `combo_evt` re-latches `combo` and reloads the hold counter (retrigger).
  - Counter reaches 0 → SCORE.
- COUNTDOWN:
  - Entry loads `value` ← `CD_SECONDS` and tick counter ← `TICK_CYCLES` − 1.
  - Each tick expiry decrements `value` while `value` > 0.
  - A tick expiring with `value` = 0 → SCORE and `cd_done` = 1 for exactly that cycle.
  - The display therefore shows CD_SECONDS, …, 1, 0, each for `TICK_CYCLES` cycles.
  - `combo_evt` is ignored in this state.
  - `start_cd` here restarts the countdown from `CD_SECONDS`.
- GAMEOVER:
  - Entry latches `sat(score)`; `value` is frozen at that number and `enable_blink` = 1.
  - `score` changes and `combo_evt` are ignored.
  - Only `start_cd` or `rst` leaves this state; a repeated `game_over` re-latches the score.
- `game_over` is accepted from every state. `start_cd` is accepted from every state and always goes to COUNTDOWN.
- Counters are 27-bit, count down, and are only active in their own state. They are cleared on entry to any other state, so retrigger and re-entry never see a stale count.

## Timing
- All outputs are registered. An event sampled high at edge N takes effect in `owner`, `value` and `enable_blink` after edge N.
- In SCORE, a `score` change is visible on `value` one cycle later.
- COMBO dwell from the event edge to the return to SCORE is exactly `HOLD_CYCLES` cycles. A retrigger restarts the full dwell.
- COUNTDOWN total dwell is (`CD_SECONDS` + 1) × `TICK_CYCLES` cycles. `cd_done` is asserted in the same cycle that `owner` returns to 0.
- Reset values: `owner` = 0 (SCORE), `value` = 0, `enable_blink` = 0, `cd_done` = 0, all counters and latches = 0.
- A reset asserted mid-countdown or mid-hold aborts without any `cd_done` pulse. The first cycle after reset tracks `score`.
- `cd_done` is never asserted by a countdown that was aborted through `game_over`, `start_cd` or `rst`.

## Test plan
Directed tests use `HOLD_CYCLES`=4, `TICK_CYCLES`=3, `CD_SECONDS`=2.
- **Reset and tracking:** assert `rst`, then release it with `score`=1234 → `owner`=0 and `value`=0 during reset, `value`=1234 one cycle after release; `score`=12000 → `value`=9999.
- **Combo hold and retrigger:** `combo`=57 with a `combo_evt` pulse → `value`=57 and `owner`=1 for 4 cycles, then back to the score. A second pulse with `combo`=58 at dwell cycle 2 → 58 is shown for 4 more cycles.
- **Countdown:** a `start_cd` pulse → `value` sequence 2,2,2,1,1,1,0,0,0. `cd_done` pulses once as `owner` returns to 0. A `combo_evt` during the countdown has no effect.
- **Game over:** `score`=321 with a `game_over` pulse → `value`=321 and `enable_blink`=1. `score`→500 leaves `value` at 321. `start_cd` → `enable_blink`=0 and the countdown starts at 2.
- **Simultaneous events:** `game_over`, `start_cd` and `combo_evt` in the same cycle → `owner`=3. `start_cd` and `combo_evt` together → `owner`=2.
- **Reset mid-countdown:** assert `rst` at count 1 → no `cd_done`, `owner`=0, `value`=0, then tracking of `score` resumes.

Source files
------------

// File: rtl/display_owner_arbiter.sv
// display_owner_arbiter
//
// Owns the 4-digit seven-segment display and decides which producer is
// shown on it: the live score, a combo pop-up, the pre-round countdown,
// or the frozen game-over score (blinking). Event pulses are arbitrated
// by fixed priority: game_over > start_cd > combo_evt. Lower-priority
// events in the same cycle are dropped. Temporary views are timed by a
// single 27-bit down counter. Only the active view uses the counter, and
// the counter is cleared whenever a state is entered that does not use it.
//
// Parameters:
//   HOLD_CYCLES  cycles a combo pop-up stays on screen (>= 1)
//   TICK_CYCLES  cycles per countdown step (>= 1)
//   CD_SECONDS   countdown start value (1..9999)
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   score        live score (binary, may exceed 9999)
//   combo        combo count, sampled on combo_evt
//   combo_evt    one-cycle pulse requesting a combo pop-up
//   start_cd     one-cycle pulse starting a countdown
//   game_over    one-cycle pulse freezing the final score
//   value        registered number for the display driver (<= 9999)
//   enable_blink registered blink request for the display driver
//   owner        current view: 0 SCORE, 1 COMBO, 2 COUNTDOWN, 3 GAMEOVER
//   cd_done      one-cycle pulse when a countdown runs to completion

module display_owner_arbiter #(
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int TICK_CYCLES = 50_000_000,
    parameter int CD_SECONDS  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] score,
    input  logic [13:0] combo,
    input  logic        combo_evt,
    input  logic        start_cd,
    input  logic        game_over,
    output logic [13:0] value,
    output logic        enable_blink,
    output logic [1:0]  owner,
    output logic        cd_done
);

    typedef enum logic [1:0] {
        SCORE     = 2'd0,
        COMBO     = 2'd1,
        COUNTDOWN = 2'd2,
        GAMEOVER  = 2'd3
    } state_t;

    localparam logic [13:0] MAX_VALUE  = 14'd9999;
    localparam logic [26:0] HOLD_LOAD  = 27'(HOLD_CYCLES - 1);
    localparam logic [26:0] TICK_LOAD  = 27'(TICK_CYCLES - 1);
    localparam logic [13:0] CD_START   = 14'(CD_SECONDS);

    state_t      state;
    logic [26:0] timer;

    // Clamp anything headed for the display to four decimal digits.
    function automatic logic [13:0] sat(input logic [13:0] x);
        return (x > MAX_VALUE) ? MAX_VALUE : x;
    endfunction

    // The state register doubles as the owner output, so owner is
    // registered without a separate flop.
    assign owner = state;

    // Single FSM block. Global events are handled first, in priority order;
    // only when neither game_over nor start_cd is present does the current
    // state's own behaviour apply. The combo pop-up value and the frozen
    // game-over score are held directly in the value register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SCORE;
            value        <= 14'd0;
            enable_blink <= 1'b0;
            cd_done      <= 1'b0;
            timer        <= 27'd0;
        end else begin
            cd_done <= 1'b0;

            if (game_over) begin
                // Also re-latches when already in GAMEOVER.
                state        <= GAMEOVER;
                value        <= sat(score);
                enable_blink <= 1'b1;
                timer        <= 27'd0;
            end else if (start_cd) begin
                // Restarts the countdown from the top when one is running.
                state        <= COUNTDOWN;
                value        <= CD_START;
                enable_blink <= 1'b0;
                timer        <= TICK_LOAD;
            end else begin
                case (state)
                    SCORE: begin
                        enable_blink <= 1'b0;
                        if (combo_evt) begin
                            state <= COMBO;
                            value <= sat(combo);
                            timer <= HOLD_LOAD;
                        end else begin
                            value <= sat(score);
                            timer <= 27'd0;
                        end
                    end

                    COMBO: begin
                        enable_blink <= 1'b0;
                        if (combo_evt) begin
                            value <= sat(combo);
                            timer <= HOLD_LOAD;
                        end else if (timer == 27'd0) begin
                            // Returning to SCORE shows the live score
                            // immediately rather than one cycle late.
                            state <= SCORE;
                            value <= sat(score);
                        end else begin
                            timer <= timer - 27'd1;
                        end
                    end

                    COUNTDOWN: begin
                        enable_blink <= 1'b0;
                        if (timer != 27'd0) begin
                            timer <= timer - 27'd1;
                        end else if (value != 14'd0) begin
                            value <= value - 14'd1;
                            timer <= TICK_LOAD;
                        end else begin
                            // The zero step has been shown for a full tick.
                            state   <= SCORE;
                            value   <= sat(score);
                            cd_done <= 1'b1;
                        end
                    end

                    GAMEOVER: begin
                        enable_blink <= 1'b1;
                        timer        <= 27'd0;
                    end

                    default: begin
                        state        <= SCORE;
                        value        <= sat(score);
                        enable_blink <= 1'b0;
                        timer        <= 27'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_owner_arbiter.sv
// Directed testbench for display_owner_arbiter with HOLD_CYCLES=4,
// TICK_CYCLES=3, CD_SECONDS=2. Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point, well away from the
// next edge.

module tb_display_owner_arbiter;

    logic        clk;
    logic        rst;
    logic [13:0] score;
    logic [13:0] combo;
    logic        combo_evt;
    logic        start_cd;
    logic        game_over;
    logic [13:0] value;
    logic        enable_blink;
    logic [1:0]  owner;
    logic        cd_done;

    int checkCount;
    int failCount;
    int cdDoneCount;

    display_owner_arbiter #(
        .HOLD_CYCLES(4),
        .TICK_CYCLES(3),
        .CD_SECONDS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .score(score),
        .combo(combo),
        .combo_evt(combo_evt),
        .start_cd(start_cd),
        .game_over(game_over),
        .value(value),
        .enable_blink(enable_blink),
        .owner(owner),
        .cd_done(cd_done)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts every cd_done pulse over the whole run, so aborted countdowns
    // that wrongly pulse are caught even between explicit checks.
    always @(negedge clk) begin
        if (cd_done) cdDoneCount++;
    end

    // Compares one observed value with its expected value.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Drives the event pulses for one clock edge and then clears them.
    task automatic applyStimulus(input logic go, input logic cd, input logic cevt);
        game_over = go;
        start_cd  = cd;
        combo_evt = cevt;
        @(posedge clk);
        #1;
        game_over = 1'b0;
        start_cd  = 1'b0;
        combo_evt = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int cdSeq [9] = '{2, 2, 2, 1, 1, 1, 0, 0, 0};

        checkCount  = 0;
        failCount   = 0;
        cdDoneCount = 0;
        rst       = 1'b1;
        score     = 14'd1234;
        combo     = 14'd0;
        combo_evt = 1'b0;
        start_cd  = 1'b0;
        game_over = 1'b0;

        // Reset and tracking
        idle(2);
        checkOutput("rst_owner", owner, 0);
        checkOutput("rst_value", value, 0);
        checkOutput("rst_blink", enable_blink, 0);
        checkOutput("rst_cd_done", cd_done, 0);
        rst = 1'b0;
        idle(1);
        checkOutput("track_1234", value, 1234);
        score = 14'd12000;
        idle(1);
        checkOutput("track_sat", value, 9999);
        score = 14'd16383;
        idle(1);
        checkOutput("track_sat_max", value, 9999);
        score = 14'd100;
        idle(1);
        checkOutput("track_100", value, 100);

        // Combo hold: four cycles of pop-up, then back to score
        combo = 14'd57;
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("combo_owner_c%0d", i), owner, 1);
            checkOutput($sformatf("combo_value_c%0d", i), value, 57);
            if (i < 4) idle(1);
        end
        idle(1);
        checkOutput("combo_end_owner", owner, 0);
        checkOutput("combo_end_value", value, 100);

        // Retrigger at dwell cycle 2 restarts a full four-cycle dwell
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("retrig_c1", value, 57);
        idle(1);
        checkOutput("retrig_c2", value, 57);
        combo = 14'd58;
        applyStimulus(1'b0, 1'b0, 1'b1);
        combo = 14'd99;
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("retrig_owner_r%0d", i), owner, 1);
            checkOutput($sformatf("retrig_value_r%0d", i), value, 58);
            if (i < 4) idle(1);
        end
        idle(1);
        checkOutput("retrig_end_owner", owner, 0);
        checkOutput("retrig_end_value", value, 100);

        // Combo value above 9999 is saturated
        combo = 14'd15000;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("combo_sat", value, 9999);
        idle(4);
        checkOutput("combo_sat_end", owner, 0);

        // Countdown 2,2,2,1,1,1,0,0,0 with a combo_evt that must be ignored
        combo = 14'd77;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("cd_value_0", value, cdSeq[0]);
        checkOutput("cd_owner_0", owner, 2);
        for (int i = 1; i < 9; i++) begin
            applyStimulus(1'b0, 1'b0, (i == 4));
            checkOutput($sformatf("cd_value_%0d", i), value, cdSeq[i]);
            checkOutput($sformatf("cd_owner_%0d", i), owner, 2);
            checkOutput($sformatf("cd_done_%0d", i), cd_done, 0);
        end
        idle(1);
        checkOutput("cd_end_owner", owner, 0);
        checkOutput("cd_end_done", cd_done, 1);
        checkOutput("cd_end_value", value, 100);
        idle(1);
        checkOutput("cd_done_drop", cd_done, 0);

        // Game over freezes and blinks
        score = 14'd321;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("go_owner", owner, 3);
        checkOutput("go_value", value, 321);
        checkOutput("go_blink", enable_blink, 1);
        score = 14'd500;
        idle(1);
        checkOutput("go_frozen", value, 321);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("go_combo_ignored_owner", owner, 3);
        checkOutput("go_combo_ignored_value", value, 321);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("go_relatch", value, 500);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("go_exit_blink", enable_blink, 0);
        checkOutput("go_exit_owner", owner, 2);
        checkOutput("go_exit_value", value, 2);

        // Simultaneous events
        idle(1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("simul_all_owner", owner, 3);
        checkOutput("simul_all_value", value, 500);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("simul_cd_owner", owner, 2);
        checkOutput("simul_cd_value", value, 2);

        // Reset at count 1 aborts without cd_done
        idle(3);
        checkOutput("abort_count1", value, 1);
        rst = 1'b1;
        idle(1);
        checkOutput("abort_owner", owner, 0);
        checkOutput("abort_value", value, 0);
        checkOutput("abort_cd_done", cd_done, 0);
        idle(1);
        rst   = 1'b0;
        score = 14'd777;
        idle(1);
        checkOutput("abort_track", value, 777);
        idle(10);
        checkOutput("abort_idle_owner", owner, 0);
        checkOutput("cd_done_total", cdDoneCount, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
